// File: rtl/cpu_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
package cpu_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned IDX_W      = 64;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // Byte address to word index; callers widen their address to IDX_W first.
    function automatic logic [IDX_W-1:0] addr_to_index(input logic [IDX_W-1:0] addr);
        return addr >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/imem_fetch_resp.sv
// Registered fetch response: returns the word read at the grant edge, or an
// error with zero data for misaligned / out-of-range fetch addresses.
module imem_fetch_resp
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DEPTH         = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     gnt_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    rdata_i,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     err_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic                  err_c;

    assign err_c = (addr_i[1:0] != 2'b00) ||
                   (addr_to_index(IDX_W'(addr_i)) >= IDX_W'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= gnt_i;
            if (gnt_i) begin
                err_q  <= err_c;
                data_q <= err_c ? '0 : rdata_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign err_o   = err_q;

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the single instruction-memory port between fetch (default owner)
// and a sequential program-loader stream.
module imem_load_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DEPTH         = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetchReq,
    input  logic [ADDRESS_WIDTH-1:0]   fetchAddr,
    output logic                       fetchGnt,
    output logic                       fetchValid,
    output logic [DATA_WIDTH-1:0]      fetchData,
    output logic                       fetchErr,
    input  logic                       loadStart,
    input  logic                       loadValid,
    input  logic [DATA_WIDTH-1:0]      loadData,
    input  logic                       loadLast,
    output logic                       loadReady,
    output logic                       loadDone,
    output logic                       loadOverflow,
    output logic [$clog2(DEPTH):0]     loadCount,
    output logic [ADDRESS_WIDTH-1:0]   memAddr,
    output logic                       memWe,
    output logic [DATA_WIDTH-1:0]      memWdata,
    input  logic [DATA_WIDTH-1:0]      memRdata
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    arb_state_e               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic                     gnt_c;
    logic                     wptr_in_range_c;

    assign wptr_in_range_c = addr_to_index(IDX_W'(wptr_q)) < IDX_W'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wptr_q  <= BASE_ADDR;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        gnt_c     = 1'b0;
        loadReady = 1'b0;
        memWe     = 1'b0;
        memWdata  = '0;
        memAddr   = fetchAddr;
        unique case (state_q)
            RUN: begin
                gnt_c = fetchReq;
                if (loadStart) begin
                    state_d = LOAD;
                    wptr_d  = BASE_ADDR;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                loadReady = 1'b1;
                memAddr   = wptr_q;
                if (loadValid) begin
                    // Words past the end still advance the pointer and count.
                    if (wptr_in_range_c) begin
                        memWe    = 1'b1;
                        memWdata = loadData;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    wptr_d = wptr_q + ADDRESS_WIDTH'(WORD_BYTES);
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (loadLast) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Grant is combinational, so hold it low while reset is asserted.
    assign fetchGnt     = gnt_c & rst_n;
    assign loadDone     = (state_q == DONE);
    assign loadCount    = cnt_q;
    assign loadOverflow = ovf_q;

    imem_fetch_resp #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DEPTH        (DEPTH)
    ) u_fetch_resp (
        .clk    (clk),
        .rst_n  (rst_n),
        .gnt_i  (gnt_c),
        .addr_i (fetchAddr),
        .rdata_i(memRdata),
        .valid_o(fetchValid),
        .data_o (fetchData),
        .err_o  (fetchErr)
    );

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: vector table plus scoreboard for fetch
// responses, and hand sequences for overflow and mid-load reset.
module tb_imem_load_arbiter;

    logic        clk;
    logic        rst_n;
    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic        loadStart, loadValid, loadLast;
    logic [31:0] loadData;

    logic        fetchGnt, fetchValid, fetchErr, loadReady, loadDone, loadOverflow, memWe;
    logic [31:0] fetchData, memAddr, memWdata, memRdata;
    logic [8:0]  loadCount;

    logic        b_fetchGnt, b_fetchValid, b_fetchErr, b_loadReady, b_loadDone, b_loadOverflow, b_memWe;
    logic [31:0] b_fetchData, b_memAddr, b_memWdata, b_memRdata;
    logic [8:0]  b_loadCount;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic        preloaded = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    imem_load_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .fetchReq(fetchReq), .fetchAddr(fetchAddr),
        .fetchGnt(fetchGnt), .fetchValid(fetchValid), .fetchData(fetchData), .fetchErr(fetchErr),
        .loadStart(loadStart), .loadValid(loadValid), .loadData(loadData), .loadLast(loadLast),
        .loadReady(loadReady), .loadDone(loadDone), .loadOverflow(loadOverflow), .loadCount(loadCount),
        .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata), .memRdata(memRdata));

    imem_load_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h3F8)) dut1 (
        .clk(clk), .rst_n(rst_n), .fetchReq(fetchReq), .fetchAddr(fetchAddr),
        .fetchGnt(b_fetchGnt), .fetchValid(b_fetchValid), .fetchData(b_fetchData), .fetchErr(b_fetchErr),
        .loadStart(loadStart), .loadValid(loadValid), .loadData(loadData), .loadLast(loadLast),
        .loadReady(b_loadReady), .loadDone(b_loadDone), .loadOverflow(b_loadOverflow), .loadCount(b_loadCount),
        .memAddr(b_memAddr), .memWe(b_memWe), .memWdata(b_memWdata), .memRdata(b_memRdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory arrays: combinational read, synchronous write, preloaded on first edge.
    always_comb memRdata   = (memAddr   < 32'h400) ? mem0[memAddr[9:2]]   : 32'h0;
    always_comb b_memRdata = (b_memAddr < 32'h400) ? mem1[b_memAddr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 32'hC0DE_0000 | 32'(i);
                mem1[i] <= 32'h0;
            end
            mem0[2]   <= 32'h2008_0005;
            preloaded <= 1'b1;
        end else begin
            if (memWe && memAddr < 32'h400)     mem0[memAddr[9:2]]   <= memWdata;
            if (b_memWe && b_memAddr < 32'h400) mem1[b_memAddr[9:2]] <= b_memWdata;
        end
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        ls, lv;
        logic [31:0] ldata;
        logic        ll;
        logic        e_gnt, e_ready, e_we, e_done, ck_addr;
        logic [31:0] e_maddr;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t sb[$];
    vec_t  tbl[21];

    function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic ls, input logic lv,
                                input logic [31:0] ldata, input logic ll, input logic e_gnt,
                                input logic e_ready, input logic e_we, input logic e_done,
                                input logic ck_addr, input logic [31:0] e_maddr,
                                input logic [31:0] e_data, input logic e_err);
        vec_t v;
        v.req = req; v.addr = addr; v.ls = ls; v.lv = lv; v.ldata = ldata; v.ll = ll;
        v.e_gnt = e_gnt; v.e_ready = e_ready; v.e_we = e_we; v.e_done = e_done;
        v.ck_addr = ck_addr; v.e_maddr = e_maddr; v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector, check same-cycle outputs, then the next-cycle response.
    task automatic run_vec(input vec_t v, input string tag);
        resp_t r;
        fetchReq = v.req; fetchAddr = v.addr; loadStart = v.ls;
        loadValid = v.lv; loadData = v.ldata; loadLast = v.ll;
        #1;
        chk({tag, ".fetchGnt"}, 64'(fetchGnt), 64'(v.e_gnt));
        chk({tag, ".loadReady"}, 64'(loadReady), 64'(v.e_ready));
        chk({tag, ".memWe"}, 64'(memWe), 64'(v.e_we));
        chk({tag, ".loadDone"}, 64'(loadDone), 64'(v.e_done));
        if (v.ck_addr) chk({tag, ".memAddr"}, 64'(memAddr), 64'(v.e_maddr));
        if (v.e_we)    chk({tag, ".memWdata"}, 64'(memWdata), 64'(v.ldata));
        if (v.e_gnt) begin
            r.data = v.e_data;
            r.err  = v.e_err;
            sb.push_back(r);
        end
        step();
        chk({tag, ".fetchValid"}, 64'(fetchValid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            r = sb.pop_front();
            if (fetchValid) begin
                chk({tag, ".fetchData"}, 64'(fetchData), 64'(r.data));
                chk({tag, ".fetchErr"}, 64'(fetchErr), 64'(r.err));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual no finish required finish by 200000");
        $fatal(1);
    end

    initial begin
        //          req addr          ls lv ldata          ll gnt rdy we dn ck maddr         data           err
        tbl[0]  = mk(1, 32'h8,        0, 0, 32'h0,         0, 1,  0,  0, 0, 1, 32'h8,        32'h2008_0005, 0);
        tbl[1]  = mk(1, 32'h6,        0, 0, 32'h0,         0, 1,  0,  0, 0, 1, 32'h6,        32'h0,         1);
        tbl[2]  = mk(1, 32'h400,      0, 0, 32'h0,         0, 1,  0,  0, 0, 1, 32'h400,      32'h0,         1);
        tbl[3]  = mk(0, 32'h10,       0, 0, 32'h0,         0, 0,  0,  0, 0, 1, 32'h10,       32'h0,         0);
        tbl[4]  = mk(1, 32'h3FC,      0, 0, 32'h0,         0, 1,  0,  0, 0, 1, 32'h3FC,      32'hC0DE_00FF, 0);
        tbl[5]  = mk(0, 32'h0,        1, 0, 32'h0,         0, 0,  0,  0, 0, 1, 32'h0,        32'h0,         0);
        tbl[6]  = mk(0, 32'h0,        0, 1, 32'hA,         0, 0,  1,  1, 0, 1, 32'h0,        32'h0,         0);
        tbl[7]  = mk(0, 32'h0,        0, 1, 32'hB,         0, 0,  1,  1, 0, 1, 32'h4,        32'h0,         0);
        tbl[8]  = mk(0, 32'h0,        0, 1, 32'hC,         1, 0,  1,  1, 0, 1, 32'h8,        32'h0,         0);
        tbl[9]  = mk(0, 32'h0,        0, 0, 32'h0,         0, 0,  0,  0, 1, 0, 32'h0,        32'h0,         0);
        tbl[10] = mk(1, 32'h4,        0, 0, 32'h0,         0, 1,  0,  0, 0, 1, 32'h4,        32'hB,         0);
        tbl[11] = mk(1, 32'h0,        1, 0, 32'h0,         0, 1,  0,  0, 0, 1, 32'h0,        32'hA,         0);
        tbl[12] = mk(1, 32'h0,        0, 0, 32'h0,         0, 0,  1,  0, 0, 1, 32'h0,        32'h0,         0);
        tbl[13] = mk(1, 32'h0,        0, 1, 32'hD,         0, 0,  1,  1, 0, 1, 32'h0,        32'h0,         0);
        tbl[14] = mk(1, 32'h0,        0, 0, 32'h0,         0, 0,  1,  0, 0, 1, 32'h4,        32'h0,         0);
        tbl[15] = mk(1, 32'h0,        1, 1, 32'hE,         1, 0,  1,  1, 0, 1, 32'h4,        32'h0,         0);
        tbl[16] = mk(1, 32'h0,        0, 0, 32'h0,         0, 0,  0,  0, 1, 0, 32'h0,        32'h0,         0);
        tbl[17] = mk(1, 32'h4,        0, 0, 32'h0,         0, 1,  0,  0, 0, 1, 32'h4,        32'hE,         0);
        tbl[18] = mk(1, 32'h0,        0, 0, 32'h0,         0, 1,  0,  0, 0, 1, 32'h0,        32'hD,         0);
        tbl[19] = mk(1, 32'h3FC,      0, 1, 32'h77,        0, 1,  0,  0, 0, 1, 32'h3FC,      32'hC0DE_00FF, 0);
        tbl[20] = mk(0, 32'h0,        0, 0, 32'h0,         0, 0,  0,  0, 0, 1, 32'h0,        32'h0,         0);

        rst_n = 1'b0;
        fetchReq = 1'b1; fetchAddr = 32'h8;
        loadStart = 1'b0; loadValid = 1'b0; loadData = 32'h0; loadLast = 1'b0;
        step();
        step();
        chk("rst.fetchGnt", 64'(fetchGnt), 64'(0));
        chk("rst.fetchValid", 64'(fetchValid), 64'(0));
        chk("rst.fetchData", 64'(fetchData), 64'(0));
        chk("rst.loadReady", 64'(loadReady), 64'(0));
        chk("rst.loadCount", 64'(loadCount), 64'(0));
        chk("rst.memWe", 64'(memWe), 64'(0));
        chk("rst.memWdata", 64'(memWdata), 64'(0));
        chk("rst.memAddr", 64'(memAddr), 64'h8);
        chk("rst.b_loadOverflow", 64'(b_loadOverflow), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i <= 10; i++) run_vec(tbl[i], $sformatf("v%0d", i));
        chk("load1.loadCount", 64'(loadCount), 64'(3));
        chk("load1.loadOverflow", 64'(loadOverflow), 64'(0));
        for (int i = 11; i <= 20; i++) run_vec(tbl[i], $sformatf("v%0d", i));
        chk("load2.loadCount", 64'(loadCount), 64'(2));

        // Overflow: dut1 starts at 0x3F8, so only the first two of four words land.
        fetchReq = 1'b0; fetchAddr = 32'h0; loadStart = 1'b1;
        step();
        loadStart = 1'b0;
        for (int k = 0; k < 4; k++) begin
            loadValid = 1'b1; loadData = 32'h11 + 32'(k); loadLast = (k == 3);
            #1;
            chk($sformatf("ovf%0d.b_memWe", k), 64'(b_memWe), 64'(k < 2));
            chk($sformatf("ovf%0d.b_memAddr", k), 64'(b_memAddr), 64'(32'h3F8 + 32'(4 * k)));
            chk($sformatf("ovf%0d.memWe", k), 64'(memWe), 64'(1));
            step();
        end
        loadValid = 1'b0; loadLast = 1'b0;
        #1;
        chk("ovf.b_loadDone", 64'(b_loadDone), 64'(1));
        chk("ovf.b_loadOverflow", 64'(b_loadOverflow), 64'(1));
        chk("ovf.b_loadCount", 64'(b_loadCount), 64'(4));
        chk("ovf.loadOverflow", 64'(loadOverflow), 64'(0));
        chk("ovf.loadCount", 64'(loadCount), 64'(4));
        step();
        chk("ovf.b_loadDone_gone", 64'(b_loadDone), 64'(0));
        chk("ovf.mem1_254", 64'(mem1[254]), 64'h11);
        chk("ovf.mem1_255", 64'(mem1[255]), 64'h12);
        chk("ovf.b_loadOverflow_hold", 64'(b_loadOverflow), 64'(1));

        // Reset in the middle of a load session.
        run_vec(mk(0, 32'h0, 1, 0, 32'h0,  0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0), "mr0");
        run_vec(mk(0, 32'h0, 0, 1, 32'h55, 0, 0, 1, 1, 0, 1, 32'h0, 32'h0, 0), "mr1");
        fetchReq = 1'b1; fetchAddr = 32'h20; loadValid = 1'b1; loadData = 32'h66;
        #1;
        chk("mr2.loadReady", 64'(loadReady), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mr3.loadReady", 64'(loadReady), 64'(0));
        chk("mr3.memWe", 64'(memWe), 64'(0));
        chk("mr3.fetchGnt", 64'(fetchGnt), 64'(0));
        chk("mr3.loadCount", 64'(loadCount), 64'(0));
        chk("mr3.memAddr", 64'(memAddr), 64'h20);
        chk("mr3.loadDone", 64'(loadDone), 64'(0));
        step();
        rst_n = 1'b1;
        run_vec(mk(1, 32'h0, 0, 1, 32'h66, 0, 1, 0, 0, 0, 1, 32'h0, 32'h55, 0), "mr4");
        run_vec(mk(1, 32'h4, 0, 0, 32'h0,  0, 1, 0, 0, 0, 1, 32'h4, 32'h12, 0), "mr5");
        chk("mr.mem0_0", 64'(mem0[0]), 64'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the single port of the writable instruction memory and shares it between two requesters:
  - the pipeline fetch stage (read);
  - a program loader stream (sequential word writes).
- Sits between the IF stage, the host/debug loader and the instruction memory array, which has a combinational read and a synchronous write.
- Fetch owns the port by default. A load session takes the port, streams words from BASE_ADDR upward, then returns the port to fetch.

Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDRESS_WIDTH, 32, byte-address width
- DEPTH, 256, memory depth in words
- BASE_ADDR, 0, byte address of the first loaded word (word-aligned)

Ports:
- clk  in  1  system clock. One clock domain; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset
- fetchReq  in  1  fetch stage requests an instruction word
- fetchAddr  in  ADDRESS_WIDTH  byte address of the fetch (the PC)
- fetchGnt  out  1  fetch request accepted this cycle (combinational)
- fetchValid  out  1  fetchData/fetchErr valid; registered, one cycle after grant
- fetchData  out  DATA_WIDTH  returned instruction word
- fetchErr  out  1  the granted fetch was misaligned or out of range
- loadStart  in  1  begin a load session (pulse)
- loadValid  in  1  loader word valid
- loadData  in  DATA_WIDTH  loader word
- loadLast  in  1  qualifies the final word of the session
- loadReady  out  1  arbiter accepts a loader word this cycle
- loadDone  out  1  one-cycle pulse when the session ends
- loadOverflow  out  1  sticky flag: a word was dropped past DEPTH
- loadCount  out  $clog2(DEPTH)+1  number of words accepted in the current/last session
- memAddr  out  ADDRESS_WIDTH  byte address to the memory
- memWe  out  1  memory write enable
- memWdata  out  DATA_WIDTH  memory write data
- memRdata  in  DATA_WIDTH  memory combinational read data

Behaviour:
- States: RUN (fetch owns the port), LOAD (loader owns the port), DONE (one cycle, then back to RUN).
- Reset (async, rst_n=0):
  - state = RUN, wptr = BASE_ADDR.
  - All outputs 0: fetchGnt, fetchValid, fetchData, fetchErr, loadReady, loadDone, loadOverflow, loadCount, memWe, memWdata.
  - memAddr follows fetchAddr.
- Reset asserted mid-LOAD aborts the session. No loadDone is emitted; words already written remain in memory.
- RUN:
  - fetchGnt = fetchReq; memAddr = fetchAddr; memWe = 0; loadReady = 0.
  - On a grant, the next cycle has fetchValid=1 and fetchData = memRdata sampled at the grant edge.
  - fetchAddr[1:0] != 0 or fetchAddr>>2 >= DEPTH: fetchErr=1 and fetchData=0 alongside fetchValid.
  - fetchValid is 0 in any cycle that does not follow a grant.
- RUN with loadStart=1:
  - A fetch granted in the same cycle still completes; its fetchValid appears next cycle.
  - Next state = LOAD; wptr = BASE_ADDR; loadCount = 0; loadOverflow cleared.
- LOAD:
  - fetchGnt = 0; fetch requests stall with no queueing.
  - loadReady = 1; memAddr = wptr.
  - On loadValid:
    - If wptr>>2 < DEPTH: memWe=1, memWdata=loadData. Otherwise the write is suppressed and loadOverflow is set.
    - Either way, wptr += 4 and loadCount++ (saturating at 2^width-1).
  - loadStart in LOAD is ignored.
  - loadValid & loadLast → DONE.
- DONE:
  - loadDone = 1 for exactly one cycle; loadReady = 0, memWe = 0, fetchGnt = 0.
  - Next state = RUN.
  - loadCount and loadOverflow hold until the next loadStart.
- loadValid in RUN/DONE is ignored (loadReady=0).
- Throughput: 1 fetch/cycle in RUN; 1 load word/cycle in LOAD.
- Port switch cost: one bubble cycle after the last load word (DONE).

Decomposition:
- Shared package (cpu_pkg):
  - state encoding typedef {RUN, LOAD, DONE};
  - WORD_BYTES=4 constant;
  - address-to-index helper function (addr>>2).
- One sub-module: imem_fetch_resp, the registered fetch-response stage (fetchValid, fetchData, fetchErr). The FSM and write pointer stay in the top module.

Test Plan:
- Reset, then fetchReq=1, fetchAddr=0x8, mem[2]=0x20080005 → fetchGnt=1 the same cycle; next cycle fetchValid=1, fetchData=0x20080005, fetchErr=0.
- fetchAddr=0x6, then fetchAddr=0x400 (DEPTH=256) → fetchValid=1, fetchErr=1, fetchData=0 for each.
- loadStart, then 3 words 0xA,0xB,0xC with loadLast on 0xC →
  - memWe on 3 consecutive cycles at memAddr 0x0,0x4,0x8;
  - loadDone pulses one cycle later; loadCount=3;
  - subsequent fetch of 0x4 returns 0xB.
- fetchReq and loadStart in the same cycle → fetch granted and returns data; fetchGnt=0 throughout LOAD while fetchReq stays 1; grant resumes the cycle after loadDone.
- BASE_ADDR=0x3F8, 4 words streamed → two writes land (0x3F8, 0x3FC); loadOverflow=1, loadCount=4, loadDone pulses.
- rst_n dropped mid-LOAD after 1 word → outputs 0 immediately; state RUN after release; no loadDone; mem[0] keeps the written word.
